// File: rtl/branch_predict_ctrl.sv
// Branch predictor and mispredict redirect/flush sequencer between IF and EX.
// Optional BRANCH_PERF_EN adds resolve and mispredict event counters.
module branch_predict_ctrl #(
  parameter int PC_WIDTH     = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PC_WIDTH-1:0] if_pc_i,
  output logic                pred_taken_o,
  input  logic                ex_branch_i,
  input  logic [PC_WIDTH-1:0] ex_pc_i,
  input  logic                ex_pred_taken_i,
  input  logic                ex_taken_i,
  input  logic [PC_WIDTH-1:0] ex_target_i,
  input  logic                stall_i,
  output logic                redirect_valid_o,
  output logic [PC_WIDTH-1:0] redirect_pc_o,
  output logic                flush_o,
`ifdef BRANCH_PERF_EN
  output logic [31:0]         branch_cnt_o,
  output logic [31:0]         mispredict_cnt_o,
`endif
  output logic                busy_o
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          fcnt_q, fcnt_d;
  logic                rv_q, rv_d;
  logic [PC_WIDTH-1:0] rpc_q, rpc_d;
  logic [1:0]          bht_q [BHT_ENTRIES];
  logic [1:0]          bht_d [BHT_ENTRIES];

  logic [IW-1:0] if_idx;
  logic [IW-1:0] ex_idx;
  logic          resolve;
  logic          mispredict;

  assign if_idx = if_pc_i[IW+1:2];
  assign ex_idx = ex_pc_i[IW+1:2];

  // Lookup reads the registered table: no same-cycle bypass.
  assign pred_taken_o = bht_q[if_idx][1];

  assign resolve    = ex_branch_i & ~stall_i & (state_q == IDLE);
  assign mispredict = resolve & (ex_pred_taken_i != ex_taken_i);

  always_comb begin
    bht_d = bht_q;
    if (resolve) begin
      if (ex_taken_i) begin
        if (bht_q[ex_idx] != 2'b11)
          bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else begin
        if (bht_q[ex_idx] != 2'b00)
          bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      fcnt_q  <= 3'd0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    rv_d    = 1'b0;
    rpc_d   = rpc_q;
    unique case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d = FLUSH;
          fcnt_d  = FC_INIT;
          rv_d    = 1'b1;
          rpc_d   = ex_taken_i ? ex_target_i
                               : ex_pc_i + PC_WIDTH'(4);
        end
      end
      FLUSH: begin
        if (fcnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_o          = (state_q == FLUSH);
    busy_o           = (state_q != IDLE);
    redirect_valid_o = rv_q;
    redirect_pc_o    = rpc_q;
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] bcnt_q, bcnt_d;
  logic [31:0] mcnt_q, mcnt_d;

  always_comb begin
    bcnt_d = bcnt_q + (resolve ? 32'd1 : 32'd0);
    mcnt_d = mcnt_q + (mispredict ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt_q <= 32'd0;
      mcnt_q <= 32'd0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign branch_cnt_o     = bcnt_q;
  assign mispredict_cnt_o = mcnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Randomized and directed bench for branch_predict_ctrl against a
// counter-table / flush-countdown reference model.
module tb_branch_predict_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred;
  logic        br;
  logic [31:0] ex_pc;
  logic        ex_pt;
  logic        ex_tk;
  logic [31:0] ex_tgt;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;
  logic        flush;
  logic        busy;
`ifdef BRANCH_PERF_EN
  logic [31:0] bcnt;
  logic [31:0] mcnt;
`endif

  branch_predict_ctrl #(
    .PC_WIDTH(32),
    .BHT_ENTRIES(16),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .if_pc_i(if_pc),
    .pred_taken_o(pred),
    .ex_branch_i(br),
    .ex_pc_i(ex_pc),
    .ex_pred_taken_i(ex_pt),
    .ex_taken_i(ex_tk),
    .ex_target_i(ex_tgt),
    .stall_i(stall),
    .redirect_valid_o(rv),
    .redirect_pc_o(rpc),
    .flush_o(flush),
`ifdef BRANCH_PERF_EN
    .branch_cnt_o(bcnt),
    .mispredict_cnt_o(mcnt),
`endif
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int          ctr [16];
  int          flush_left;
  bit          m_rv;
  logic [31:0] m_rpc;
  int          m_bcnt;
  int          m_mcnt;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hF);
  endfunction

  function automatic bit mpred(input logic [31:0] pc);
    return ctr[idx(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ctr[i] = 1;
    flush_left = 0;
    m_rv = 0;
    m_rpc = 32'h0;
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  task automatic drive(input bit b, input logic [31:0] pc, input bit pt,
                       input bit tk, input logic [31:0] tgt, input bit st,
                       input logic [31:0] ipc);
    br = b; ex_pc = pc; ex_pt = pt; ex_tk = tk;
    ex_tgt = tgt; stall = st; if_pc = ipc;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".pred"}, {31'd0, pred}, {31'd0, mpred(if_pc)});
    chk({tag, ".rv"}, {31'd0, rv}, {31'd0, m_rv});
    chk({tag, ".rpc"}, rpc, m_rpc);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, flush_left > 0});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, flush_left > 0});
`ifdef BRANCH_PERF_EN
    chk({tag, ".bcnt"}, bcnt, 32'(m_bcnt));
    chk({tag, ".mcnt"}, mcnt, 32'(m_mcnt));
`endif
  endtask

  // One clock: check at the falling edge, then advance the model.
  task automatic cyc(input string tag);
    bit res;
    bit mis;
    int i;
    @(negedge clk);
    check_outs(tag);
    res = br && !stall && flush_left == 0;
    mis = res && (ex_pt != ex_tk);
    i = idx(ex_pc);
    @(posedge clk);
    if (flush_left > 0) flush_left--;
    m_rv = 0;
    if (res) begin
      m_bcnt++;
      if (ex_tk) ctr[i] = (ctr[i] == 3) ? 3 : ctr[i] + 1;
      else       ctr[i] = (ctr[i] == 0) ? 0 : ctr[i] - 1;
    end
    if (mis) begin
      m_mcnt++;
      flush_left = FC;
      m_rv = 1;
      m_rpc = ex_tk ? ex_tgt : ex_pc + 32'd4;
    end
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 32'h100);
    for (int k = 0; k < n; k++) cyc("idle");
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 32'h100);
    rst_n = 1'b0;
    model_reset();
    #12;
    check_outs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // train 0x100: first resolve mispredicts, second is correct
    cyc("lookup100");
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h100, mpred(32'h100), 1, 32'h180, 0, 32'h100);
      cyc("train100");
      idle(FC + 1);
    end
    chk("pred100_taken", {31'd0, pred}, 32'd1);

    // taken mispredict at 0x200; branch held during flush is ignored
    drive(1, 32'h200, 0, 1, 32'h240, 0, 32'h200);
    cyc("mis200");
    chk("rpc240", rpc, 32'h240);
    drive(1, 32'h200, 1, 0, 32'h240, 0, 32'h200);
    cyc("wrongpath1");
    cyc("wrongpath2");
    idle(2);

    // not-taken mispredict wrapping past the top of the address space
    drive(1, 32'hFFFF_FFFC, 1, 0, 32'h40, 0, 32'hFFFF_FFFC);
    cyc("wrap");
    chk("rpc_wrap", rpc, 32'h0);
    idle(FC + 1);

    // stalled branch resolves exactly once on release
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h500, mpred(32'h500), 0, 32'h0, 1, 32'h500);
      cyc("stall");
    end
    drive(1, 32'h500, mpred(32'h500), 0, 32'h0, 0, 32'h500);
    cyc("release");
    idle(2);

    // reset during first flush cycle
    drive(1, 32'h200, 1, 0, 32'h0, 0, 32'h200);
    cyc("mis200b");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("midreset");
    drive(0, 0, 0, 0, 0, 0, 32'h200);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(3);
    drive(1, 32'h200, 0, 1, 32'h240, 0, 32'h200);
    cyc("post_rst");
    drive(0, 0, 0, 0, 0, 0, 32'h200);
    idle(FC + 1);
    chk("ctr200_was01", {31'd0, pred}, 32'd1);

    // saturate at 00, then same-cycle lookup and update
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h300, mpred(32'h300), 0, 32'h0, 0, 32'h300);
      cyc("sat300");
    end
    chk("sat_pred0", {31'd0, pred}, 32'd0);
    drive(1, 32'h300, 0, 1, 32'h340, 0, 32'h300);
    cyc("same_cycle");
    idle(FC + 1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pc;
      logic [31:0] ipc;
      bit pt;
      pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                        : {22'd0, 8'($urandom), 2'b00};
      ipc = ($urandom_range(0, 1) == 0) ? pc : ($urandom & ~32'h3);
      pt  = ($urandom_range(0, 3) != 0) ? mpred(pc) : 1'($urandom);
      drive(1'($urandom_range(0, 2) != 0), pc, pt, 1'($urandom),
            $urandom & ~32'h3, ($urandom_range(0, 4) == 0), ipc);
      cyc("rand");
    end
    idle(FC + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch sequencing controller between the IF and EX stages.
- Holds a direct-mapped table of 2-bit saturating counters and supplies a taken prediction to IF.
- Consumes the EX-stage branch_taken result and updates the table.
- On a misprediction, issues a registered redirect PC and holds a multi-cycle flush through an FSM.

Parameters:
- PC_WIDTH, 32, width of all PC and target buses.
- BHT_ENTRIES, 16, number of counters; must be a power of two, at least 2.
- FLUSH_CYCLES, 2, cycles flush_o stays high per misprediction; legal range 1..7.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- if_pc_i  in  PC_WIDTH  fetch PC used for the lookup.
- pred_taken_o  out  1  combinational prediction for if_pc_i: counter[1] of the indexed entry.
- ex_branch_i  in  1  EX stage holds a conditional branch.
- ex_pc_i  in  PC_WIDTH  PC of the EX branch.
- ex_pred_taken_i  in  1  prediction carried down the pipe with this branch.
- ex_taken_i  in  1  actual outcome from the branch comparator.
- ex_target_i  in  PC_WIDTH  computed branch target.
- stall_i  in  1  pipeline stall; blocks resolution.
- redirect_valid_o  out  1  one-cycle pulse: fetch must load redirect_pc_o.
- redirect_pc_o  out  PC_WIDTH  corrected fetch PC.
- flush_o  out  1  kill IF/ID contents while high.
- busy_o  out  1  FSM is not in IDLE.

Behaviour:
- Index: idx = PC[log2(BHT_ENTRIES)+1 : 2]. The same slice is used for both IF lookup and EX update.
- Reset (async, rst_ni=0):
  - All counters set to 2'b01 (weakly not-taken).
  - FSM set to IDLE; flush counter set to 0.
  - redirect_valid_o=0, redirect_pc_o=0, flush_o=0, busy_o=0.
  - Reset asserted mid-flush aborts the flush immediately; no redirect is produced after reset releases.
- Resolve event: resolve = ex_branch_i & ~stall_i & (state==IDLE).
  - Branches presented while in FLUSH are ignored. They are the wrong path and are not trained.
  - Branches held under stall_i are not resolved until the stall releases, and are resolved exactly once.
- Counter update, on the edge where resolve=1:
  - ex_taken_i=1: increment, saturating at 2'b11.
  - ex_taken_i=0: decrement, saturating at 2'b00.
- Same-cycle lookup/update to the same index: pred_taken_o shows the pre-update value. There is no bypass.
- Mispredict: mispredict = resolve & (ex_pred_taken_i != ex_taken_i).
- FSM states:
  - IDLE:
    - On mispredict, go to FLUSH with flush counter = FLUSH_CYCLES-1.
    - On the same edge, register redirect_valid_o=1 and redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_i+4. The +4 is modulo 2^PC_WIDTH, so wrap-around at the top is allowed.
  - FLUSH:
    - flush_o=1 and busy_o=1.
    - redirect_valid_o falls after one cycle; redirect_pc_o holds its value.
    - Counter decrements each cycle; at 0 the FSM returns to IDLE on the next edge.
    - stall_i does not pause the flush.
- Latency: a resolve at edge N gives redirect_valid_o and flush_o high in cycle N+1. flush_o is high for exactly FLUSH_CYCLES cycles, and the FSM is back in IDLE at cycle N+1+FLUSH_CYCLES.
- Back-to-back: a correctly predicted branch produces no flush and no redirect. A mispredict in the first IDLE cycle after a flush is accepted normally.
- Correct predictions still train the counter.

Optional Feature:
- Macro: BRANCH_PERF_EN.
- When defined:
  - Adds outputs branch_cnt_o[31:0] and mispredict_cnt_o[31:0].
  - They count resolve events and mispredict events respectively.
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset, then look up if_pc_i=0x100 → pred_taken_o=0. Then resolve ex_pc_i=0x100 taken twice with ex_pred_taken_i matching the current prediction → counter 01→10→11. Exactly one mispredict occurs (the first), and pred_taken_o=1 afterwards.
- Mispredict with ex_pc_i=0x200, ex_pred_taken_i=0, ex_taken_i=1, ex_target_i=0x240 → next cycle redirect_valid_o=1 and redirect_pc_o=0x240. flush_o is high for 2 cycles, then busy_o=0.
- Mispredict with ex_pred_taken_i=1, ex_taken_i=0, ex_pc_i=0xFFFFFFFC → redirect_pc_o=0x00000000 (wrap).
- ex_branch_i held high during FLUSH with mismatching prediction → no counter change and no second redirect. With stall_i=1 on a branch for 3 cycles → no update until release, then exactly one update.
- Assert rst_ni low in the first flush cycle → all outputs 0 immediately; after release, the counter at 0x200 reads 01 and no redirect appears.
- Saturation: 5 not-taken resolves at 0x300 → counter stays 00. Same-cycle lookup and update of 0x300 (taken) → pred_taken_o still shows the old value that cycle.
